// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared bus widths, register addresses and helpers for the register file
package reg_file_pkg;

  localparam int REG_ADDR_BUS = 5;
  localparam int DATA_BUS     = 32;
  localparam int REG_NUM      = 32;

  localparam logic [REG_ADDR_BUS-1:0] ZERO_REG_ADDR = 5'd0;
  localparam logic [REG_ADDR_BUS-1:0] RA_REG_ADDR   = 5'd31;

  typedef logic [REG_ADDR_BUS-1:0] reg_addr_t;
  typedef logic [DATA_BUS-1:0]     data_t;

  // r0 is hardwired to zero, so it can never be a write or bypass target
  function automatic logic is_writable(input reg_addr_t addr);
    return addr != ZERO_REG_ADDR;
  endfunction

endpackage

// File: rtl/reg_read_port.sv
// rtl/reg_read_port.sv - one combinational read port: reset / enable / zero / bypass / array priority mux
module reg_read_port
  import reg_file_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int WIDTH    = 32
) (
  input  logic                           rst,
  input  logic                           read_en,
  input  reg_addr_t                      read_addr,
  input  logic                           write_en,
  input  reg_addr_t                      write_addr,
  input  logic [WIDTH-1:0]               write_data,
  input  logic [NUM_REGS-1:0][WIDTH-1:0] regs,
  output logic [WIDTH-1:0]               read_data
);

  // Zero unless reset is released, the port is enabled and the address is not r0;
  // a same-cycle write-back to the same register is forwarded ahead of storage
  always_comb begin
    read_data = '0;
    if (rst && read_en && is_writable(read_addr)) begin
      if (write_en && (write_addr == read_addr)) begin
        read_data = write_data;
      end else begin
        read_data = regs[read_addr];
      end
    end
  end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x32 register file with two bypassed read ports; REG_FILE_DEBUG_EN adds a registered write trace
module reg_file #(
  parameter int REG_NUM    = reg_file_pkg::REG_NUM,
  parameter int DATA_WIDTH = reg_file_pkg::DATA_BUS
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 read_en_1,
  input  logic [reg_file_pkg::REG_ADDR_BUS-1:0] read_addr_1,
  output logic [DATA_WIDTH-1:0]                read_data_1,
  input  logic                                 read_en_2,
  input  logic [reg_file_pkg::REG_ADDR_BUS-1:0] read_addr_2,
  output logic [DATA_WIDTH-1:0]                read_data_2,
  input  logic                                 write_en,
  input  logic [reg_file_pkg::REG_ADDR_BUS-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0]                write_data
`ifdef REG_FILE_DEBUG_EN
  ,
  output logic                                 debug_reg_write_en,
  output logic [reg_file_pkg::REG_ADDR_BUS-1:0] debug_reg_write_addr,
  output logic [DATA_WIDTH-1:0]                debug_reg_write_data
`endif
);

  import reg_file_pkg::*;

  logic [REG_NUM-1:0][DATA_WIDTH-1:0] regs;
  logic                               wr_fire;

  assign wr_fire = write_en && is_writable(write_addr);

  // Architectural storage: reset clears every register, otherwise commit the WB write
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = int'(ZERO_REG_ADDR); i <= int'(RA_REG_ADDR); i++) begin
        regs[i] <= '0;
      end
    end else if (wr_fire) begin
      regs[write_addr] <= write_data;
    end
  end

  reg_read_port #(.NUM_REGS(REG_NUM), .WIDTH(DATA_WIDTH)) u_read_port_1 (
    .rst        (rst),
    .read_en    (read_en_1),
    .read_addr  (read_addr_1),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .regs       (regs),
    .read_data  (read_data_1)
  );

  reg_read_port #(.NUM_REGS(REG_NUM), .WIDTH(DATA_WIDTH)) u_read_port_2 (
    .rst        (rst),
    .read_en    (read_en_2),
    .read_addr  (read_addr_2),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .regs       (regs),
    .read_data  (read_data_2)
  );

`ifdef REG_FILE_DEBUG_EN
  // Commit trace: registered copy of the write that actually landed, zeroed when none did
  always_ff @(posedge clk) begin
    if (!rst) begin
      debug_reg_write_en   <= 1'b0;
      debug_reg_write_addr <= '0;
      debug_reg_write_data <= '0;
    end else begin
      debug_reg_write_en   <= wr_fire;
      debug_reg_write_addr <= wr_fire ? write_addr : '0;
      debug_reg_write_data <= wr_fire ? write_data : '0;
    end
  end
`endif

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - self-checking bench for reg_file with a register-array reference model
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic        read_en_1;
  logic [4:0]  read_addr_1;
  logic [31:0] read_data_1;
  logic        read_en_2;
  logic [4:0]  read_addr_2;
  logic [31:0] read_data_2;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
`ifdef REG_FILE_DEBUG_EN
  logic        debug_reg_write_en;
  logic [4:0]  debug_reg_write_addr;
  logic [31:0] debug_reg_write_data;
`endif

  int passed = 0;
  int total  = 0;
  bit chk_on = 0;

  logic [31:0] m_regs [32];
  logic        m_dbg_en;
  logic [4:0]  m_dbg_addr;
  logic [31:0] m_dbg_data;

  reg_file dut (
    .clk         (clk),
    .rst         (rst),
    .read_en_1   (read_en_1),
    .read_addr_1 (read_addr_1),
    .read_data_1 (read_data_1),
    .read_en_2   (read_en_2),
    .read_addr_2 (read_addr_2),
    .read_data_2 (read_data_2),
    .write_en    (write_en),
    .write_addr  (write_addr),
    .write_data  (write_data)
`ifdef REG_FILE_DEBUG_EN
    ,
    .debug_reg_write_en   (debug_reg_write_en),
    .debug_reg_write_addr (debug_reg_write_addr),
    .debug_reg_write_data (debug_reg_write_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] exp_read(input logic en, input logic [4:0] addr);
    if (!rst || !en || addr == 5'd0) return 32'h0;
    if (write_en && write_addr == addr) return write_data;
    return m_regs[addr];
  endfunction

  // Reference model: architectural register contents and last committed write
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_dbg_en = 1'b0; m_dbg_addr = 5'd0; m_dbg_data = 32'h0;
    end else begin
      m_dbg_en = write_en && write_addr != 5'd0;
      m_dbg_addr = write_addr;
      m_dbg_data = write_data;
      if (m_dbg_en) m_regs[write_addr] = write_data;
    end
  end

  // Every-cycle comparison of both read ports (and trace outputs) against the model
  always @(negedge clk) begin
    if (chk_on) begin
      check("rd1_model", read_data_1, exp_read(read_en_1, read_addr_1));
      check("rd2_model", read_data_2, exp_read(read_en_2, read_addr_2));
`ifdef REG_FILE_DEBUG_EN
      check("dbg_en_model", {31'h0, debug_reg_write_en}, {31'h0, m_dbg_en});
      if (m_dbg_en) begin
        check("dbg_addr_model", {27'h0, debug_reg_write_addr}, {27'h0, m_dbg_addr});
        check("dbg_data_model", debug_reg_write_data, m_dbg_data);
      end
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
    rst = r; write_en = we; write_addr = wa; write_data = wd;
    read_en_1 = e1; read_addr_1 = a1; read_en_2 = e2; read_addr_2 = a2;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_dbg_en = 1'b0; m_dbg_addr = 5'd0; m_dbg_data = 32'h0;
    set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b1, 5'd2);
    chk_on = 1;

    @(negedge clk);
    check("reset_rd1", read_data_1, 32'h0);
    check("reset_rd2", read_data_2, 32'h0);
    tick();
`ifdef REG_FILE_DEBUG_EN
    check("reset_dbg_en", {31'h0, debug_reg_write_en}, 32'h0);
    check("reset_dbg_data", debug_reg_write_data, 32'h0);
`endif

    // Fill r1..r31 with all-ones; port 1 bypasses the write, port 2 reads the previous one
    for (int i = 1; i < 32; i++) begin
      set_in(1'b1, 1'b1, 5'(i), 32'hFFFF_FFFF, 1'b1, 5'(i), 1'b1, 5'(i - 1));
      @(negedge clk);
      check("prefill_bypass", read_data_1, 32'hFFFF_FFFF);
      tick();
    end

    // Reset collides with a write to r31: reset wins, even over the bypass
    set_in(1'b0, 1'b1, 5'd31, 32'h0000_BEEF, 1'b1, 5'd31, 1'b1, 5'd30);
    @(negedge clk);
    check("rst_bypass_rd1", read_data_1, 32'h0);
    check("rst_bypass_rd2", read_data_2, 32'h0);
    tick();

    // Every register reads back zero after the single reset cycle
    for (int i = 1; i < 32; i++) begin
      set_in(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(32 - i));
      @(negedge clk);
      check("post_reset_rd1", read_data_1, 32'h0);
      check("post_reset_rd2", read_data_2, 32'h0);
      tick();
    end

    // Write r5, read it back next cycle; disabled port 2 stays zero
    set_in(1'b1, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    set_in(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd5);
    @(negedge clk);
    check("r5_readback", read_data_1, 32'h1234_5678);
    check("r5_port2_disabled", read_data_2, 32'h0);
    tick();

    // Both ports bypass the same write in the same cycle
    set_in(1'b1, 1'b1, 5'd8, 32'hDEAD_BEEF, 1'b1, 5'd8, 1'b1, 5'd8);
    @(negedge clk);
    check("bypass_rd1", read_data_1, 32'hDEAD_BEEF);
    check("bypass_rd2", read_data_2, 32'hDEAD_BEEF);
    tick();

    // Writing r0 is discarded and never bypassed
    set_in(1'b1, 1'b1, 5'd0, 32'hAAAA_5555, 1'b1, 5'd0, 1'b1, 5'd0);
    @(negedge clk);
    check("r0_same_rd1", read_data_1, 32'h0);
    check("r0_same_rd2", read_data_2, 32'h0);
    tick();
`ifdef REG_FILE_DEBUG_EN
    check("r0_dbg_en", {31'h0, debug_reg_write_en}, 32'h0);
`endif
    set_in(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd8);
    @(negedge clk);
    check("r0_next_rd1", read_data_1, 32'h0);
    check("r8_stored_rd2", read_data_2, 32'hDEAD_BEEF);
    tick();

    // A pending write to a different address must not disturb storage reads
    set_in(1'b1, 1'b1, 5'd9, 32'h0BAD_F00D, 1'b1, 5'd5, 1'b1, 5'd9);
    @(negedge clk);
    check("nonmatch_rd1", read_data_1, 32'h1234_5678);
    check("bypass_r9_rd2", read_data_2, 32'h0BAD_F00D);
    tick();

    // Commit trace lags each write edge by one cycle
    set_in(1'b1, 1'b1, 5'd2, 32'h1, 1'b1, 5'd3, 1'b1, 5'd2);
    tick();
`ifdef REG_FILE_DEBUG_EN
    check("dbg1_en", {31'h0, debug_reg_write_en}, 32'h1);
    check("dbg1_addr", {27'h0, debug_reg_write_addr}, 32'd2);
    check("dbg1_data", debug_reg_write_data, 32'h1);
`endif
    set_in(1'b1, 1'b1, 5'd3, 32'h2, 1'b1, 5'd2, 1'b1, 5'd3);
    @(negedge clk);
    check("r2_after_write", read_data_1, 32'h1);
    tick();
`ifdef REG_FILE_DEBUG_EN
    check("dbg2_en", {31'h0, debug_reg_write_en}, 32'h1);
    check("dbg2_addr", {27'h0, debug_reg_write_addr}, 32'd3);
    check("dbg2_data", debug_reg_write_data, 32'h2);
`endif
    set_in(1'b1, 1'b0, 5'd3, 32'h7, 1'b1, 5'd3, 1'b1, 5'd2);
    @(negedge clk);
    check("r3_no_bypass_when_we0", read_data_1, 32'h2);
    tick();
`ifdef REG_FILE_DEBUG_EN
    check("dbg3_en", {31'h0, debug_reg_write_en}, 32'h0);
`endif

    @(negedge clk);
    chk_on = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
